// File: rtl/cobra_pkg.sv
// Shared definitions for the Cobra multi-cycle core: instruction layout,
// write-select and ALU opcodes, and the control FSM state type.
package cobra_pkg;

  localparam int INSTR_W = 32;
  localparam int CONST_W = 23;

  // Field order matches the instruction word from bit 31 down to bit 0.
  typedef struct packed {
    logic       b;
    logic       c;
    logic [1:0] ws;
    logic [4:0] op;
    logic [4:0] ra1;
    logic [4:0] ra2;
    logic [7:0] off;
    logic [4:0] wa;
  } instr_t;

  localparam logic [1:0] WS_NONE  = 2'b00;
  localparam logic [1:0] WS_IN    = 2'b01;
  localparam logic [1:0] WS_CONST = 2'b10;
  localparam logic [1:0] WS_ALU   = 2'b11;

  localparam logic [4:0] ALUOP_ADD = 5'b00000;
  localparam logic [4:0] ALUOP_SUB = 5'b00001;
  localparam logic [4:0] ALUOP_AND = 5'b00010;
  localparam logic [4:0] ALUOP_OR  = 5'b00011;
  localparam logic [4:0] ALUOP_XOR = 5'b00100;
  localparam logic [4:0] ALUOP_SLL = 5'b00101;
  localparam logic [4:0] ALUOP_SRL = 5'b00110;
  localparam logic [4:0] ALUOP_SRA = 5'b00111;
  localparam logic [4:0] ALUOP_SLT = 5'b01000;
  localparam logic [4:0] ALUOP_EQ  = 5'b11000;
  localparam logic [4:0] ALUOP_NE  = 5'b11001;
  localparam logic [4:0] ALUOP_LT  = 5'b11100;
  localparam logic [4:0] ALUOP_GE  = 5'b11101;
  localparam logic [4:0] OP_HALT   = 5'b11110;
  localparam logic [4:0] OP_OUT    = 5'b11111;

  typedef enum logic [2:0] {
    ST_FETCH,
    ST_EXEC,
    ST_WAIT_IN,
    ST_WAIT_OUT,
    ST_HALT
  } state_e;

  // The constant overlays the ALUOP, RA1, RA2 and OFF fields.
  function automatic logic [CONST_W-1:0] instr_const(input instr_t i);
    return {i.op, i.ra1, i.ra2, i.off};
  endfunction

endpackage

// File: rtl/cobra_alu.sv
// Combinational ALU: arithmetic/logic results plus comparison flags for
// conditional jumps. Flag ops return a zero result.
module cobra_alu
  import cobra_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [4:0]        i_op,
  input  logic [DATA_W-1:0] i_a,
  input  logic [DATA_W-1:0] i_b,
  output logic [DATA_W-1:0] o_result,
  output logic              o_flag
);

  logic [4:0] w_shamt;
  logic       w_lt;

  assign w_shamt = i_b[4:0];
  assign w_lt    = $signed(i_a) < $signed(i_b);

  always_comb begin
    // NOTE: every output gets a default before the case so no path leaves
    // a value unassigned, which would otherwise infer a latch.
    o_result = '0;
    o_flag   = 1'b0;
    case (i_op)
      ALUOP_ADD: o_result = i_a + i_b;
      ALUOP_SUB: o_result = i_a - i_b;
      ALUOP_AND: o_result = i_a & i_b;
      ALUOP_OR:  o_result = i_a | i_b;
      ALUOP_XOR: o_result = i_a ^ i_b;
      ALUOP_SLL: o_result = i_a << w_shamt;
      ALUOP_SRL: o_result = i_a >> w_shamt;
      ALUOP_SRA: o_result = $unsigned($signed(i_a) >>> w_shamt);
      ALUOP_SLT: o_result = {{(DATA_W-1){1'b0}}, w_lt};
      ALUOP_EQ:  o_flag   = (i_a == i_b);
      ALUOP_NE:  o_flag   = (i_a != i_b);
      ALUOP_LT:  o_flag   = w_lt;
      ALUOP_GE:  o_flag   = !w_lt;
      default:   ;
    endcase
  end

endmodule

// File: rtl/cobra_mc_core.sv
// Cobra multi-cycle core: FETCH/EXEC sequencing over a synchronous ROM, with
// valid/ready handshakes on the input and output ports and a sticky HALT.
module cobra_mc_core
  import cobra_pkg::*;
#(
  parameter int DATA_W     = 32,
  parameter int PC_W       = 8,
  parameter int NREG       = 32,
  parameter int REG0_ZERO  = 1,
  parameter int CONST_SEXT = 0
) (
  input  logic                CLK,
  input  logic                RST_N,
  output logic [PC_W-1:0]     imem_addr,
  input  logic [INSTR_W-1:0]  imem_rdata,
  input  logic [DATA_W-1:0]   in_data,
  input  logic                in_valid,
  output logic                in_ready,
  output logic [DATA_W-1:0]   out_data,
  output logic                out_valid,
  input  logic                out_ready,
  output logic                halted,
  output logic [PC_W-1:0]     pc_dbg
);

  localparam int RA_W = (NREG > 1) ? $clog2(NREG) : 1;

  state_e              r_state, w_state_nxt;
  logic [PC_W-1:0]     r_pc, r_pc_target, w_pc_nxt, w_pc_val;
  logic [4:0]          r_wa, w_wa;
  logic [DATA_W-1:0]   r_regs [NREG];
  logic [DATA_W-1:0]   r_out_data, w_wd;
  logic                r_out_valid;
  logic                w_we, w_pc_upd;

  instr_t              w_instr;
  logic [DATA_W-1:0]   w_rd1, w_rd2, w_alu_res, w_const;
  logic [CONST_W-1:0]  w_const_raw;
  logic                w_flag, w_take, w_is_out, w_is_halt;

  // The ROM word is only meaningful during EXEC; everything decoded from it
  // that later states need is captured at the end of EXEC.
  assign w_instr = instr_t'(imem_rdata);

  function automatic logic addr_ok(input logic [4:0] a);
    return (int'(a) < NREG) && !((REG0_ZERO != 0) && (a == 5'd0));
  endfunction

  assign w_rd1 = addr_ok(w_instr.ra1) ? r_regs[w_instr.ra1[RA_W-1:0]] : '0;
  assign w_rd2 = addr_ok(w_instr.ra2) ? r_regs[w_instr.ra2[RA_W-1:0]] : '0;

  cobra_alu #(.DATA_W(DATA_W)) u_alu (
    .i_op     (w_instr.op),
    .i_a      (w_rd1),
    .i_b      (w_rd2),
    .o_result (w_alu_res),
    .o_flag   (w_flag)
  );

  assign w_const_raw = instr_const(w_instr);
  assign w_const = (CONST_SEXT != 0)
                 ? {{(DATA_W-CONST_W){w_const_raw[CONST_W-1]}}, w_const_raw}
                 : {{(DATA_W-CONST_W){1'b0}}, w_const_raw};

  assign w_is_out  = (w_instr.ws == WS_NONE) && (w_instr.op == OP_OUT);
  assign w_is_halt = (w_instr.ws == WS_NONE) && (w_instr.op == OP_HALT);

  // Low PC_W bits of the sign-extended offset give the same sum mod 2^PC_W.
  assign w_take   = w_instr.b | (w_instr.c & w_flag);
  assign w_pc_nxt = r_pc + (w_take ? w_instr.off[PC_W-1:0] : PC_W'(1));

  always_comb begin
    w_state_nxt = r_state;
    w_we        = 1'b0;
    w_wa        = w_instr.wa;
    w_wd        = w_alu_res;
    w_pc_upd    = 1'b0;
    w_pc_val    = r_pc_target;
    case (r_state)
      ST_FETCH: w_state_nxt = ST_EXEC;
      ST_EXEC: begin
        if (w_instr.ws == WS_IN) begin
          w_state_nxt = ST_WAIT_IN;
        end else if (w_is_out) begin
          w_state_nxt = ST_WAIT_OUT;
        end else if (w_is_halt) begin
          w_state_nxt = ST_HALT;
        end else begin
          w_state_nxt = ST_FETCH;
          w_we        = (w_instr.ws != WS_NONE);
          w_wd        = (w_instr.ws == WS_CONST) ? w_const : w_alu_res;
          w_pc_upd    = 1'b1;
          w_pc_val    = w_pc_nxt;
        end
      end
      ST_WAIT_IN: begin
        if (in_valid) begin
          w_state_nxt = ST_FETCH;
          w_we        = 1'b1;
          w_wa        = r_wa;
          w_wd        = in_data;
          w_pc_upd    = 1'b1;
        end
      end
      ST_WAIT_OUT: begin
        if (out_ready) begin
          w_state_nxt = ST_FETCH;
          w_pc_upd    = 1'b1;
        end
      end
      ST_HALT: ;
      default: w_state_nxt = ST_FETCH;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    // NOTE: sequential state uses non-blocking assignment so every flop
    // samples pre-edge values regardless of statement order.
    if (!RST_N) r_state <= ST_FETCH;
    else        r_state <= w_state_nxt;
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_pc        <= '0;
      r_pc_target <= '0;
      r_wa        <= '0;
      r_out_data  <= '0;
      r_out_valid <= 1'b0;
    end else begin
      if (w_pc_upd) r_pc <= w_pc_val;
      if (r_state == ST_EXEC) begin
        r_pc_target <= w_pc_nxt;
        r_wa        <= w_instr.wa;
      end
      if ((r_state == ST_EXEC) && w_is_out) begin
        r_out_data  <= w_rd1;
        r_out_valid <= 1'b1;
      end else if ((r_state == ST_WAIT_OUT) && out_ready) begin
        r_out_valid <= 1'b0;
      end
    end
  end

  // NOTE: the register file is architecturally cleared on reset, so it is
  // built from resettable flops rather than a RAM macro.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      for (int i = 0; i < NREG; i++) r_regs[i] <= '0;
    end else if (w_we && addr_ok(w_wa)) begin
      r_regs[w_wa[RA_W-1:0]] <= w_wd;
    end
  end

  assign imem_addr = r_pc;
  assign pc_dbg    = r_pc;
  assign in_ready  = (r_state == ST_WAIT_IN);
  assign halted    = (r_state == ST_HALT);
  assign out_data  = r_out_data;
  assign out_valid = r_out_valid;

endmodule

// File: tb/tb_cobra_mc_core.sv
// Directed bench for cobra_mc_core: an ALU vector table run through IN/OUT
// programs, plus hand-written sequences for branches, handshakes and reset.
module tb_cobra_mc_core;

  localparam logic [4:0] O_ADD = 5'd0,  O_SUB = 5'd1,  O_AND = 5'd2,  O_OR  = 5'd3;
  localparam logic [4:0] O_XOR = 5'd4,  O_SLL = 5'd5,  O_SRL = 5'd6,  O_SRA = 5'd7;
  localparam logic [4:0] O_SLT = 5'd8,  O_EQ  = 5'd24, O_NE  = 5'd25, O_BAD = 5'd9;
  localparam logic [4:0] O_HLT = 5'd30, O_OUT = 5'd31;

  logic        CLK, RST_N;
  logic [7:0]  imem_addr, pc_dbg;
  logic [31:0] imem_rdata, in_data, out_data;
  logic        in_valid, in_ready, out_valid, out_ready, halted;
  logic [31:0] rom [256];

  int n_checks = 0;
  int n_fail   = 0;

  cobra_mc_core dut (
    .CLK(CLK), .RST_N(RST_N), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .halted(halted), .pc_dbg(pc_dbg)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  always @(posedge CLK) imem_rdata <= rom[imem_addr];

  function automatic logic [31:0] enc(input logic b, input logic c, input logic [1:0] ws,
                                      input logic [4:0] op, input logic [4:0] ra1,
                                      input logic [4:0] ra2, input logic [7:0] off,
                                      input logic [4:0] wa);
    return {b, c, ws, op, ra1, ra2, off, wa};
  endfunction
  function automatic logic [31:0] i_const(input logic [22:0] k, input logic [4:0] wa);
    return {2'b00, 2'b10, k, wa};
  endfunction
  function automatic logic [31:0] i_in(input logic [4:0] wa);
    return enc(1'b0, 1'b0, 2'b01, 5'd0, 5'd0, 5'd0, 8'd0, wa);
  endfunction
  function automatic logic [31:0] i_out(input logic [4:0] ra);
    return enc(1'b0, 1'b0, 2'b00, O_OUT, ra, 5'd0, 8'd0, 5'd0);
  endfunction
  function automatic logic [31:0] i_halt();
    return enc(1'b0, 1'b0, 2'b00, O_HLT, 5'd0, 5'd0, 8'd0, 5'd0);
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    end
  endtask

  task automatic clear_rom();
    for (int i = 0; i < 256; i++) rom[i] = i_halt();
  endtask

  task automatic do_reset();
    RST_N = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
    repeat (2) @(negedge CLK);
    RST_N = 1'b1;
  endtask

  task automatic feed_in(input logic [31:0] v, input string nm);
    int n = 0;
    in_data = v; in_valid = 1'b1;
    while (!in_ready && n < 100) begin @(negedge CLK); n++; end
    check({nm, " in_ready"}, 32'(in_ready), 32'd1);
    @(negedge CLK);
    in_valid = 1'b0;
  endtask

  task automatic get_out(input logic [31:0] exp, input string nm);
    int n = 0;
    out_ready = 1'b1;
    while (!out_valid && n < 100) begin @(negedge CLK); n++; end
    check({nm, " out_valid"}, 32'(out_valid), 32'd1);
    check(nm, out_data, exp);
    @(negedge CLK);
  endtask

  task automatic wait_halt(input string nm);
    int n = 0;
    while (!halted && n < 200) begin @(negedge CLK); n++; end
    check({nm, " halted"}, 32'(halted), 32'd1);
  endtask

  typedef struct {
    string       name;
    logic [4:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
  } alu_vec_t;

  alu_vec_t vecs[13];

  initial begin : main
    logic [7:0]  seq[$];
    logic [31:0] got, held;
    int          vcnt;
    logic        ok_a, ok_b, ok_c, ok_d;

    vecs[0]  = '{"add_ovf", O_ADD, 32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000};
    vecs[1]  = '{"add_wrap", O_ADD, 32'hFFFF_FFFF, 32'h0000_0002, 32'h0000_0001};
    vecs[2]  = '{"sub_neg", O_SUB, 32'd5, 32'd7, 32'hFFFF_FFFE};
    vecs[3]  = '{"and", O_AND, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'hF000_F000};
    vecs[4]  = '{"or", O_OR, 32'hF0F0_F0F0, 32'h0F00_000F, 32'hFFF0_F0FF};
    vecs[5]  = '{"xor", O_XOR, 32'hAAAA_5555, 32'hFFFF_0000, 32'h5555_5555};
    vecs[6]  = '{"sll_b40", O_SLL, 32'h0000_0001, 32'h0000_0021, 32'h0000_0002};
    vecs[7]  = '{"srl", O_SRL, 32'h8000_0000, 32'd4, 32'h0800_0000};
    vecs[8]  = '{"sra", O_SRA, 32'h8000_0000, 32'd4, 32'hF800_0000};
    vecs[9]  = '{"slt_true", O_SLT, 32'hFFFF_FFFF, 32'd1, 32'd1};
    vecs[10] = '{"slt_false", O_SLT, 32'd5, 32'd3, 32'd0};
    vecs[11] = '{"eq_res0", O_EQ, 32'd3, 32'd3, 32'd0};
    vecs[12] = '{"bad_op", O_BAD, 32'h1234_5678, 32'h1111_1111, 32'd0};

    RST_N = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
    clear_rom();
    #2 RST_N = 1'b0;
    #1;
    check("rst pc", 32'(pc_dbg), 32'd0);
    check("rst imem_addr", 32'(imem_addr), 32'd0);
    check("rst out_data", out_data, 32'd0);
    check("rst out_valid", 32'(out_valid), 32'd0);
    check("rst in_ready", 32'(in_ready), 32'd0);
    check("rst halted", 32'(halted), 32'd0);

    // ALU table: IN r1, IN r2, op r3=r1,r2, OUT r3, HALT
    foreach (vecs[k]) begin
      clear_rom();
      rom[0] = i_in(5'd1);
      rom[1] = i_in(5'd2);
      rom[2] = enc(1'b0, 1'b0, 2'b11, vecs[k].op, 5'd1, 5'd2, 8'd0, 5'd3);
      rom[3] = i_out(5'd3);
      do_reset();
      feed_in(vecs[k].a, {vecs[k].name, " a"});
      feed_in(vecs[k].b, {vecs[k].name, " b"});
      get_out(vecs[k].exp, vecs[k].name);
    end

    // Constants, ADD, OUT with sink ready: one-cycle out_valid, then HALT
    clear_rom();
    rom[0] = i_const(23'd5, 5'd1);
    rom[1] = i_const(23'd7, 5'd2);
    rom[2] = enc(1'b0, 1'b0, 2'b11, O_ADD, 5'd1, 5'd2, 8'd0, 5'd3);
    rom[3] = i_out(5'd3);
    do_reset();
    vcnt = 0; got = '0;
    for (int i = 0; i < 30; i++) begin
      @(negedge CLK);
      if (out_valid) begin vcnt++; got = out_data; end
    end
    check("t1 out_data", got, 32'd12);
    check("t1 valid cycles", 32'(vcnt), 32'd1);
    check("t1 halted", 32'(halted), 32'd1);
    check("t1 halt pc", 32'(pc_dbg), 32'd4);

    // Input handshake stalls with in_valid low
    clear_rom();
    rom[0] = i_in(5'd4);
    rom[1] = i_out(5'd4);
    do_reset();
    for (int n = 0; n < 20 && !in_ready; n++) @(negedge CLK);
    ok_a = 1'b1; ok_b = 1'b1;
    for (int i = 0; i < 10; i++) begin
      if (!in_ready) ok_a = 1'b0;
      if (pc_dbg != 8'd0) ok_b = 1'b0;
      @(negedge CLK);
    end
    check("t2 in_ready held", 32'(ok_a), 32'd1);
    check("t2 pc held", 32'(ok_b), 32'd1);
    feed_in(32'h0000_DEAD, "t2 in");
    check("t2 pc advance", 32'(pc_dbg), 32'd1);
    check("t2 in_ready drop", 32'(in_ready), 32'd0);
    get_out(32'h0000_DEAD, "t2 r4");

    // Conditional EQ branch with negative offset at pc=5
    for (int r2 = 3; r2 <= 4; r2++) begin
      clear_rom();
      rom[0] = i_const(23'd3, 5'd1);
      rom[1] = i_const(23'(r2), 5'd2);
      rom[2] = enc(1'b1, 1'b0, 2'b00, O_ADD, 5'd0, 5'd0, 8'd3, 5'd0);
      rom[5] = enc(1'b0, 1'b1, 2'b00, O_EQ, 5'd1, 5'd2, 8'hFE, 5'd0);
      do_reset();
      wait_halt("t3");
      check((r2 == 3) ? "t3 taken pc" : "t3 not-taken pc", 32'(pc_dbg),
            (r2 == 3) ? 32'd3 : 32'd6);
    end

    // PC wrap 0xFF -> 0x00 on a jump that also writes a constant
    clear_rom();
    rom[0]   = enc(1'b0, 1'b1, 2'b00, O_EQ, 5'd7, 5'd0, 8'hFF, 5'd0);
    rom[1]   = i_out(5'd7);
    rom[255] = {1'b1, 1'b0, 2'b10, 23'h000001, 5'd7};
    do_reset();
    seq.delete();
    seq.push_back(pc_dbg);
    got = 32'hFFFF_FFFF;
    for (int i = 0; i < 100 && !halted; i++) begin
      @(negedge CLK);
      if (pc_dbg != seq[$]) seq.push_back(pc_dbg);
      if (out_valid) got = out_data;
    end
    check("t4 pc steps", 32'(seq.size()), 32'd5);
    if (seq.size() == 5) begin
      check("t4 pc@1", 32'(seq[1]), 32'h0000_00FF);
      check("t4 wrap", 32'(seq[2]), 32'd0);
      check("t4 pc@3", 32'(seq[3]), 32'd1);
      check("t4 pc@4", 32'(seq[4]), 32'd2);
    end
    check("t4 jump+write", got, 32'd1);

    // OUT back-pressure, then sticky HALT
    clear_rom();
    rom[0] = i_const(23'h40_0123, 5'd1);
    rom[1] = i_out(5'd1);
    do_reset();
    out_ready = 1'b0;
    for (int n = 0; n < 20 && !out_valid; n++) @(negedge CLK);
    check("t5 out zext", out_data, 32'h0040_0123);
    held = out_data;
    ok_a = 1'b1; ok_b = 1'b1; ok_c = 1'b1; ok_d = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge CLK);
      if (out_data != held) ok_a = 1'b0;
      if (!out_valid) ok_b = 1'b0;
      if (pc_dbg != 8'd1) ok_c = 1'b0;
      if (imem_addr != 8'd1) ok_d = 1'b0;
    end
    check("t5 data stable", 32'(ok_a), 32'd1);
    check("t5 valid held", 32'(ok_b), 32'd1);
    check("t5 pc frozen", 32'(ok_c), 32'd1);
    check("t5 no fetch", 32'(ok_d), 32'd1);
    out_ready = 1'b1;
    @(negedge CLK);
    check("t5 valid clear", 32'(out_valid), 32'd0);
    check("t5 pc after", 32'(pc_dbg), 32'd2);
    wait_halt("t5");
    ok_a = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge CLK);
      if (!halted || pc_dbg != 8'd2 || in_ready) ok_a = 1'b0;
    end
    check("t5 halt sticky", 32'(ok_a), 32'd1);

    // Reset during WAIT_IN; r0 writes are dropped
    clear_rom();
    rom[0] = i_const(23'h55, 5'd0);
    rom[1] = i_const(23'h66, 5'd1);
    rom[2] = i_out(5'd1);
    rom[3] = i_in(5'd3);
    rom[4] = i_out(5'd0);
    rom[5] = i_out(5'd3);
    do_reset();
    get_out(32'h66, "t6 pre");
    for (int n = 0; n < 20 && !in_ready; n++) @(negedge CLK);
    check("t6 wait pc", 32'(pc_dbg), 32'd3);
    in_data = 32'h99; in_valid = 1'b1;
    #2 RST_N = 1'b0;
    #1;
    check("t6 rst in_ready", 32'(in_ready), 32'd0);
    check("t6 rst pc", 32'(pc_dbg), 32'd0);
    check("t6 rst out_data", out_data, 32'd0);
    check("t6 rst halted", 32'(halted), 32'd0);
    @(negedge CLK);
    check("t6 in_ready in rst", 32'(in_ready), 32'd0);
    in_valid = 1'b0;
    @(negedge CLK);
    RST_N = 1'b1;
    check("t6 restart pc", 32'(pc_dbg), 32'd0);
    get_out(32'h66, "t6 rerun");
    feed_in(32'h77, "t6 in");
    get_out(32'd0, "t6 r0 zero");
    get_out(32'h77, "t6 r3");
    wait_halt("t6");

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
